// File: rtl/spi_peak_tx.sv
// spi_peak_tx: finds the largest positive-half FFT bin per frame and serves it as a 32-bit SPI mode-0 word.
// Build option: define PEAK_THRESH_EN to report bin 0 whenever the frame peak is below THRESH.
module spi_peak_tx #(
  parameter int          BIT_WIDTH = 16,
  parameter int          N         = 9,
  parameter int          FFT_SIZE  = 512,
  parameter logic [16:0] THRESH    = 17'd64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 cs,
  input  logic                 fft_valid,
  input  logic [N-1:0]         fft_idx,
  input  logic [BIT_WIDTH-1:0] fft_re,
  input  logic [BIT_WIDTH-1:0] fft_im,
  output logic                 miso,
  output logic                 result_new,
  output logic [N-2:0]         peak_bin,
  output logic [16:0]          peak_mag
);

  // IDLE: cs high, miso low | SHIFT: bit 31 on miso, shift on sclk falls | DRAIN: word sent, miso low
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  localparam logic [N-1:0] LAST_IDX = N'(FFT_SIZE - 1);
  localparam logic [N-1:0] HALF_IDX = N'(FFT_SIZE / 2);

  logic [BIT_WIDTH-1:0] abs_re, abs_im;
  logic [16:0]          mag;
  logic                 in_half, frame_end;

  logic [16:0]  run_max_q, run_max_d;
  logic [N-2:0] run_bin_q, run_bin_d;
  logic [16:0]  hold_mag_q, hold_mag_d;
  logic [N-2:0] hold_bin_q, hold_bin_d;
  logic         new_q, new_d;
  logic         ovr_q, ovr_d;

  logic [2:0] cs_sync_q, sclk_sync_q;
  logic       cs_fall, cs_rise, sclk_fall;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d;
  logic [7:0]  bin_ext;
  logic [31:0] result_word;
  logic        read_done;

  // Two's-complement negate of the most negative value yields 2^(BIT_WIDTH-1) read as unsigned.
  assign abs_re = fft_re[BIT_WIDTH-1] ? (~fft_re + BIT_WIDTH'(1)) : fft_re;
  assign abs_im = fft_im[BIT_WIDTH-1] ? (~fft_im + BIT_WIDTH'(1)) : fft_im;
  assign mag    = 17'(abs_re) + 17'(abs_im);

  assign in_half   = (fft_idx != '0) && (fft_idx < HALF_IDX);
  assign frame_end = fft_valid && (fft_idx == LAST_IDX);

  always_comb begin
    run_max_d  = run_max_q;
    run_bin_d  = run_bin_q;
    hold_mag_d = hold_mag_q;
    hold_bin_d = hold_bin_q;
    new_d      = new_q;
    ovr_d      = ovr_q;

    if (fft_valid) begin
      if (fft_idx == '0) begin
        run_max_d = '0;
        run_bin_d = '0;
      end else if (in_half && (mag > run_max_q)) begin
        run_max_d = mag;
        run_bin_d = fft_idx[N-2:0];
      end
    end

    if (read_done) begin
      new_d = 1'b0;
      ovr_d = 1'b0;
    end

    // Frame end overrides a same-cycle read completion.
    if (frame_end) begin
      hold_mag_d = run_max_q;
      hold_bin_d = run_bin_q;
`ifdef PEAK_THRESH_EN
      if (run_max_q < THRESH) hold_bin_d = '0;
`endif
      if (new_q) ovr_d = 1'b1;
      new_d = 1'b1;
    end
  end

`ifndef PEAK_THRESH_EN
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_max_q  <= '0;
      run_bin_q  <= '0;
      hold_mag_q <= '0;
      hold_bin_q <= '0;
      new_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      run_max_q  <= run_max_d;
      run_bin_q  <= run_bin_d;
      hold_mag_q <= hold_mag_d;
      hold_bin_q <= hold_bin_d;
      new_q      <= new_d;
      ovr_q      <= ovr_d;
    end
  end

  // Stage [0],[1] synchronise; stage [2] is the edge-detect history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_sync_q   <= 3'b111;
      sclk_sync_q <= 3'b000;
    end else begin
      cs_sync_q   <= {cs_sync_q[1:0], cs};
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
    end
  end

  assign cs_fall   =  cs_sync_q[2]   & ~cs_sync_q[1];
  assign cs_rise   = ~cs_sync_q[2]   &  cs_sync_q[1];
  assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];

  always_comb begin
    bin_ext          = '0;
    bin_ext[N-2:0]   = hold_bin_q;
    result_word      = {new_q, ovr_q, bin_ext, 5'b0, hold_mag_q};
  end

  assign read_done = cs_rise && (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;

    if (cs_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (cs_fall) begin
            sr_d    = result_word;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_fall) begin
            sr_d  = {sr_q[30:0], 1'b0};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = DRAIN;
          end
        end
        DRAIN: begin
          state_d = DRAIN;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  assign miso       = (state_q == SHIFT) && sr_q[31];
  assign result_new = new_q;
  assign peak_bin   = hold_bin_q;
  assign peak_mag   = hold_mag_q;

endmodule

// File: tb/tb_spi_peak_tx.sv
// tb_spi_peak_tx: directed and randomized frames against a frame-level peak model, read back over SPI.
module tb_spi_peak_tx;

  localparam int FS = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        cs;
  logic        fft_valid;
  logic [8:0]  fft_idx;
  logic [15:0] fft_re;
  logic [15:0] fft_im;
  logic        miso;
  logic        result_new;
  logic [7:0]  peak_bin;
  logic [16:0] peak_mag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit v;
    int idx;
    int re;
    int im;
  } beat_t;

  beat_t q[$];

  bit m_new, m_ovr;
  int m_bin, m_mag;

  logic [31:0] rd_word;
  int          extra_ones;

  spi_peak_tx dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .cs         (cs),
    .fft_valid  (fft_valid),
    .fft_idx    (fft_idx),
    .fft_re     (fft_re),
    .fft_im     (fft_im),
    .miso       (miso),
    .result_new (result_new),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int absv(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int rnd();
    if ($urandom_range(0, 15) == 0) return -32768;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic logic [31:0] mword();
    return {m_new, m_ovr, 8'(m_bin), 5'b0, 17'(m_mag)};
  endfunction

  task automatic add(input bit v, input int idx, input int re, input int im);
    beat_t b;
    b.v = v; b.idx = idx; b.re = re; b.im = im;
    q.push_back(b);
  endtask

  // Peak over the beats following the last valid bin-0 beat; first arrival wins ties.
  task automatic model_peak(output int bin, output int mag);
    int start;
    start = 0;
    foreach (q[i]) if (q[i].v && q[i].idx == 0) start = i;
    bin = 0;
    mag = 0;
    for (int i = start; i < q.size(); i++) begin
      if (q[i].v && q[i].idx >= 1 && q[i].idx < FS / 2 &&
          absv(q[i].re) + absv(q[i].im) > mag) begin
        mag = absv(q[i].re) + absv(q[i].im);
        bin = q[i].idx;
      end
    end
`ifdef PEAK_THRESH_EN
    if (mag < 64) bin = 0;
`endif
  endtask

  task automatic model_frame_end(input int bin, input int mag);
    if (m_new) m_ovr = 1'b1;
    m_new = 1'b1;
    m_bin = bin;
    m_mag = mag;
  endtask

  task automatic drive_q();
    foreach (q[i]) begin
      fft_valid = q[i].v;
      fft_idx   = 9'(q[i].idx);
      fft_re    = 16'(q[i].re);
      fft_im    = 16'(q[i].im);
      tick(1);
    end
    fft_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag);
    int pb, pm;
    drive_q();
    model_peak(pb, pm);
    model_frame_end(pb, pm);
    chk({tag, " bin"}, 32'(peak_bin), 32'(m_bin));
    chk({tag, " mag"}, 32'(peak_mag), 32'(m_mag));
    chk({tag, " new"}, 32'(result_new), 32'(m_new));
  endtask

  task automatic one_peak(input int bin, input int re, input int im, input string tag);
    q.delete();
    add(1, 0, 0, 0);
    add(1, bin, re, im);
    add(1, FS - 1, 0, 0);
    run_frame(tag);
  endtask

  // One sclk period per bit: miso is sampled as sclk rises, then sclk falls to advance.
  task automatic shift_seg(input int first, input int nb);
    for (int k = first; k < first + nb; k++) begin
      sclk = 1'b1;
      if (k < 32) rd_word[31-k] = miso;
      else if (miso !== 1'b0) extra_ones++;
      tick(5);
      sclk = 1'b0;
      tick(5);
    end
  endtask

  task automatic spi_read(input int nb, input int extra, input string tag);
    logic [31:0] exp_w, mask;
    exp_w = mword();
    mask  = (nb >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> nb);
    cs = 1'b0;
    tick(5);
    rd_word    = '0;
    extra_ones = 0;
    shift_seg(0, nb + extra);
    cs = 1'b1;
    tick(5);
    chk({tag, " word"}, rd_word & mask, exp_w & mask);
    if (extra > 0) chk({tag, " extra"}, 32'(extra_ones), 32'd0);
    if (nb >= 32) begin
      m_new = 1'b0;
      m_ovr = 1'b0;
    end
    chk({tag, " new"}, 32'(result_new), 32'(m_new));
  endtask

  initial begin
    int          pb, pm;
    logic [31:0] exp_w;

    reset = 1'b0; cs = 1'b1; sclk = 1'b0; fft_valid = 1'b0;
    fft_idx = '0; fft_re = '0; fft_im = '0;
    m_new = 1'b0; m_ovr = 1'b0; m_bin = 0; m_mag = 0;
    rd_word = '0; extra_ones = 0;
    tick(3);
    reset = 1'b1;
    tick(2);
    chk("reset miso", 32'(miso), 32'd0);
    chk("reset new", 32'(result_new), 32'd0);
    chk("reset bin", 32'(peak_bin), 32'd0);
    chk("reset mag", 32'(peak_mag), 32'd0);

    one_peak(37, 1000, -500, "f37");
    spi_read(32, 0, "f37 rd");
    chk("f37 literal", rd_word, 32'h8940_05DC);

    q.delete();
    add(1, 0, 0, 0);
    add(1, 10, 300, 0);
    add(1, 20, 0, -300);
    add(1, 300, 5000, 0);
    add(1, FS - 1, 0, 0);
    run_frame("tie");
    chk("tie literal", 32'(peak_bin), 32'd10);
    spi_read(32, 0, "tie rd");

    one_peak(5, 100, 100, "two a");
    one_peak(6, 50, 0, "two b");
    spi_read(32, 0, "ovr rd");
    chk("ovr flags", 32'(rd_word[31:30]), 32'd3);
    chk("ovr bin", 32'(rd_word[29:22]), 32'd6);
    spi_read(32, 8, "reread");
    chk("reread flags", 32'(rd_word[31:30]), 32'd0);

    one_peak(8, -32768, -32768, "minval");
    spi_read(16, 0, "abort");
    chk("abort new", 32'(result_new), 32'd1);

    // Read completion and a frame end land in the same clock.
    q.delete();
    add(1, 0, 0, 0);
    add(1, 77, 300, -20);
    add(1, FS - 1, 0, 0);
    model_peak(pb, pm);
    exp_w = mword();
    cs = 1'b0;
    tick(5);
    rd_word = '0;
    shift_seg(0, 32);
    chk("coincide word", rd_word, exp_w);
    fft_valid = 1'b1; fft_idx = 9'd0; fft_re = '0; fft_im = '0;
    tick(1);
    fft_idx = 9'd77; fft_re = 16'd300; fft_im = 16'(-20);
    tick(1);
    fft_valid = 1'b0;
    cs = 1'b1;
    tick(2);
    fft_valid = 1'b1; fft_idx = 9'(FS - 1); fft_re = '0; fft_im = '0;
    tick(1);
    fft_valid = 1'b0;
    model_frame_end(pb, pm);
    tick(4);
    chk("coincide new", 32'(result_new), 32'd1);
    chk("coincide bin", 32'(peak_bin), 32'd77);
    spi_read(32, 0, "coincide rd");
    chk("coincide ovr", 32'(rd_word[30]), 32'd1);

    one_peak(50, 700, 0, "mid50");
    exp_w = mword();
    cs = 1'b0;
    tick(5);
    rd_word = '0;
    shift_seg(0, 16);
    one_peak(60, 900, 0, "mid60");
    shift_seg(16, 16);
    cs = 1'b1;
    tick(5);
    chk("mid word", rd_word, exp_w);
    m_new = 1'b0;
    m_ovr = 1'b0;
    chk("mid new", 32'(result_new), 32'd0);
    spi_read(32, 0, "after mid");
    chk("after mid bin", 32'(rd_word[29:22]), 32'd60);

    q.delete();
    add(1, 0, 0, 0);
    add(1, 7, 9000, 0);
    add(0, 0, 0, 0);
    add(1, 0, 0, 0);
    add(1, 9, 5, -5);
    add(0, FS - 1, 20000, 0);
    add(1, FS - 1, 0, 0);
    run_frame("restart");
    spi_read(32, 0, "restart rd");

    one_peak(12, 60, -3, "th63");
`ifdef PEAK_THRESH_EN
    chk("th63 literal", 32'(peak_bin), 32'd0);
`else
    chk("th63 literal", 32'(peak_bin), 32'd12);
`endif
    spi_read(32, 0, "th63 rd");
    one_peak(12, 60, -4, "th64");
    chk("th64 literal", 32'(peak_bin), 32'd12);
    spi_read(32, 0, "th64 rd");

    for (int r = 0; r < 4; r++) begin
      q.delete();
      for (int i = 0; i < FS; i++) begin
        if ($urandom_range(0, 9) == 0) add(0, int'($urandom_range(0, FS - 1)), rnd(), rnd());
        add(1, i, rnd(), rnd());
        if (r == 1 && i == 100) add(1, 0, rnd(), rnd());
      end
      run_frame("rand");
      if (r % 2 == 1) spi_read(32, 0, "rand rd");
    end

    one_peak(35, 400, 400, "pre rst");
    exp_w = mword();
    cs = 1'b0;
    tick(5);
    rd_word = '0;
    shift_seg(0, 8);
    chk("pre rst miso", 32'(miso), 32'(exp_w[23]));
    reset = 1'b0;
    tick(1);
    chk("rst miso", 32'(miso), 32'd0);
    chk("rst new", 32'(result_new), 32'd0);
    chk("rst mag", 32'(peak_mag), 32'd0);
    chk("rst bin", 32'(peak_bin), 32'd0);
    cs = 1'b1;
    tick(1);
    reset = 1'b1;
    m_new = 1'b0; m_ovr = 1'b0; m_bin = 0; m_mag = 0;
    tick(5);
    spi_read(32, 0, "post rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
